// File: rtl/timer_pkg.sv
// Shared types and constants for the multi-channel timer.
package timer_pkg;

  typedef enum logic [0:0] {
    T_IDLE = 1'b0,
    T_RUN  = 1'b1
  } timer_state_t;

  localparam int unsigned CHANNELS_MIN = 1;
  localparam int unsigned CHANNELS_MAX = 16;
  localparam int unsigned WIDTH_MIN    = 2;
  localparam int unsigned WIDTH_MAX    = 16;
  localparam int unsigned PRESCALE_MIN = 1;
  localparam int unsigned PRESCALE_MAX = 256;

  // Prescaler counter width; a divisor of 1 still needs one flop.
  function automatic int unsigned ps_width(input int unsigned p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction

endpackage

// File: rtl/multi_timer_if.sv
// Control/status bundle for the multi-channel timer.
interface multi_timer_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 11
) ();

  logic [CHANNELS-1:0]            load;
  logic [CHANNELS-1:0][WIDTH-1:0] load_val;
  logic [CHANNELS-1:0]            start;
  logic [CHANNELS-1:0]            stop;
  logic [CHANNELS-1:0]            oneshot;
  logic [CHANNELS-1:0]            tick;
  logic [CHANNELS-1:0]            busy;
  logic [CHANNELS-1:0][WIDTH-1:0] count;

  modport master (
    output load, load_val, start, stop, oneshot,
    input  tick, busy, count
  );

  modport slave (
    input  load, load_val, start, stop, oneshot,
    output tick, busy, count
  );

endinterface

// File: rtl/timer_channel.sv
// One down-counting timer channel: reload register, one-shot/periodic mode.
module timer_channel
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             oneshot,
  output logic             tick,
  output logic             busy,
  output logic [WIDTH-1:0] count
);

  timer_state_t     state_q, state_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             mode_q, mode_d;
  logic             tick_q, tick_d;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= T_IDLE;
      reload_q <= '0;
      count_q  <= '0;
      mode_q   <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      count_q  <= count_d;
      mode_q   <= mode_d;
      tick_q   <= tick_d;
    end
  end

  // Next-state: stop beats start, start beats countdown; a same-cycle load feeds start directly.
  always_comb begin
    state_d  = state_q;
    reload_d = load ? load_val : reload_q;
    count_d  = count_q;
    mode_d   = mode_q;
    tick_d   = 1'b0;
    if (stop) begin
      state_d = T_IDLE;
    end else if (start) begin
      state_d = T_RUN;
      count_d = load ? load_val : reload_q;
      mode_d  = oneshot;
    end else if (state_q == T_RUN && en) begin
      if (count_q == '0) begin
        tick_d  = 1'b1;
        count_d = reload_q;
        if (mode_q) begin
          state_d = T_IDLE;
        end
      end else begin
        count_d = count_q - WIDTH'(1);
      end
    end
  end

  assign tick  = tick_q;
  assign busy  = (state_q == T_RUN);
  assign count = count_q;

endmodule

// File: rtl/multi_timer.sv
// Bank of independent timer channels sharing one free-running prescaler.
module multi_timer
  import timer_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 11,
  parameter int unsigned PRESCALE = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  multi_timer_if.slave  bus
);

  localparam int unsigned PW = ps_width(PRESCALE);
  localparam logic [PW-1:0] PS_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0]                  ps_q;
  logic                           en;
  logic [CHANNELS-1:0]            tick_w;
  logic [CHANNELS-1:0]            busy_w;
  logic [CHANNELS-1:0][WIDTH-1:0] count_w;

  // Free-running prescaler; start never disturbs its phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_q <= PS_MAX;
    end else if (ps_q == '0) begin
      ps_q <= PS_MAX;
    end else begin
      ps_q <= ps_q - PW'(1);
    end
  end

  assign en = (ps_q == '0);

  for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
    timer_channel #(
      .WIDTH (WIDTH)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .load     (bus.load[i]),
      .load_val (bus.load_val[i]),
      .start    (bus.start[i]),
      .stop     (bus.stop[i]),
      .oneshot  (bus.oneshot[i]),
      .tick     (tick_w[i]),
      .busy     (busy_w[i]),
      .count    (count_w[i])
    );
  end

  assign bus.tick  = tick_w;
  assign bus.busy  = busy_w;
  assign bus.count = count_w;

endmodule

// File: tb/tb_multi_timer.sv
// Directed self-checking bench for multi_timer.
module tb_multi_timer;

  logic clk;
  logic rst_n;
  int   errs   = 0;
  int   checks = 0;

  multi_timer_if #(.CHANNELS(4), .WIDTH(11)) bus_a ();
  multi_timer_if #(.CHANNELS(1), .WIDTH(4))  bus_b ();

  multi_timer #(.CHANNELS(4), .WIDTH(11), .PRESCALE(2)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  multi_timer #(.CHANNELS(1), .WIDTH(4), .PRESCALE(1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_a.load = '0; bus_a.load_val = '0; bus_a.start = '0; bus_a.stop = '0; bus_a.oneshot = '0;
    bus_b.load = '0; bus_b.load_val = '0; bus_b.start = '0; bus_b.stop = '0; bus_b.oneshot = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus_a.tick !== 4'b0000) begin errs++; $display("FAIL reset_tick: got %b want 0000", bus_a.tick); end
    checks++;
    if (bus_a.busy !== 4'b0000) begin errs++; $display("FAIL reset_busy: got %b want 0000", bus_a.busy); end
    checks++;
    if (bus_a.count !== 44'd0) begin errs++; $display("FAIL reset_count: got %h want 0", bus_a.count); end
    rst_n = 1'b1;
    repeat (4) step();
    checks++;
    if (bus_a.busy !== 4'b0000 || bus_b.busy !== 1'b0) begin
      errs++; $display("FAIL reset_idle_after_release: got %b/%b want 0000/0", bus_a.busy, bus_b.busy);
    end
  endtask

  task automatic test_periodic();
    int n;
    bit busy_drop;
    bus_a.load_val[0] = 11'd3; bus_a.load[0] = 1'b1;
    step();
    bus_a.load[0] = 1'b0;
    checks++;
    if (bus_a.count[0] !== 11'd0) begin errs++; $display("FAIL load_keeps_count: got %0d want 0", bus_a.count[0]); end
    bus_a.oneshot[0] = 1'b0; bus_a.start[0] = 1'b1;
    step();
    bus_a.start[0] = 1'b0;
    checks++;
    if (bus_a.busy[0] !== 1'b1 || bus_a.count[0] !== 11'd3) begin
      errs++; $display("FAIL periodic_start: got busy=%b count=%0d want busy=1 count=3", bus_a.busy[0], bus_a.count[0]);
    end
    n = 0;
    while (bus_a.tick[0] !== 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (bus_a.tick[0] !== 1'b1) begin errs++; $display("FAIL periodic_first_tick: got timeout want tick"); end
    busy_drop = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (bus_a.tick[0] !== 1'b0) begin errs++; $display("FAIL periodic_width: got tick=%b want 0", bus_a.tick[0]); end
      n = 1;
      while (bus_a.tick[0] !== 1'b1 && n < 20) begin
        if (bus_a.busy[0] !== 1'b1) busy_drop = 1'b1;
        step(); n++;
      end
      checks++;
      if (n !== 8) begin errs++; $display("FAIL periodic_period: got %0d want 8", n); end
    end
    checks++;
    if (busy_drop !== 1'b0) begin errs++; $display("FAIL periodic_busy: got busy drop want steady 1"); end
    bus_a.stop[0] = 1'b1;
    step();
    bus_a.stop[0] = 1'b0;
    checks++;
    if (bus_a.busy[0] !== 1'b0) begin errs++; $display("FAIL periodic_stop: got busy=%b want 0", bus_a.busy[0]); end
  endtask

  task automatic test_oneshot_zero();
    int n;
    int extra;
    bit busy_seen;
    bus_a.load_val[1] = 11'd0; bus_a.load[1] = 1'b1;
    bus_a.oneshot[1] = 1'b1; bus_a.start[1] = 1'b1;
    step();
    bus_a.load[1] = 1'b0; bus_a.start[1] = 1'b0; bus_a.oneshot[1] = 1'b0;
    checks++;
    if (bus_a.busy[1] !== 1'b1 || bus_a.count[1] !== 11'd0) begin
      errs++; $display("FAIL oneshot_start: got busy=%b count=%0d want busy=1 count=0", bus_a.busy[1], bus_a.count[1]);
    end
    n = 0;
    while (bus_a.tick[1] !== 1'b1 && n < 4) begin step(); n++; end
    checks++;
    if (bus_a.tick[1] !== 1'b1) begin errs++; $display("FAIL oneshot_tick: got timeout want tick"); end
    checks++;
    if (bus_a.busy[1] !== 1'b0 || bus_a.count[1] !== 11'd0) begin
      errs++; $display("FAIL oneshot_idle: got busy=%b count=%0d want busy=0 count=0", bus_a.busy[1], bus_a.count[1]);
    end
    extra = 0; busy_seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (bus_a.tick[1] === 1'b1) extra++;
      if (bus_a.busy[1] !== 1'b0) busy_seen = 1'b1;
    end
    checks++;
    if (extra !== 0 || busy_seen !== 1'b0) begin
      errs++; $display("FAIL oneshot_quiet: got ticks=%0d busy_seen=%b want 0/0", extra, busy_seen);
    end
  endtask

  task automatic test_load_start();
    logic [10:0] c;
    int extra;
    bus_a.load_val[2] = 11'd100; bus_a.load[2] = 1'b1; bus_a.start[2] = 1'b1;
    step();
    bus_a.load[2] = 1'b0; bus_a.start[2] = 1'b0;
    repeat (5) step();
    bus_a.load_val[2] = 11'd5; bus_a.load[2] = 1'b1; bus_a.start[2] = 1'b1;
    step();
    bus_a.load[2] = 1'b0; bus_a.start[2] = 1'b0;
    checks++;
    if (bus_a.count[2] !== 11'd5 || bus_a.busy[2] !== 1'b1 || bus_a.tick[2] !== 1'b0) begin
      errs++; $display("FAIL load_start_same: got count=%0d busy=%b tick=%b want 5/1/0",
                       bus_a.count[2], bus_a.busy[2], bus_a.tick[2]);
    end
    step();
    c = bus_a.count[2];
    bus_a.stop[2] = 1'b1; bus_a.start[2] = 1'b1;
    step();
    bus_a.stop[2] = 1'b0; bus_a.start[2] = 1'b0;
    checks++;
    if (bus_a.busy[2] !== 1'b0 || bus_a.tick[2] !== 1'b0 || bus_a.count[2] !== c) begin
      errs++; $display("FAIL stop_wins: got busy=%b tick=%b count=%0d want 0/0/%0d",
                       bus_a.busy[2], bus_a.tick[2], bus_a.count[2], c);
    end
    extra = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus_a.tick[2] === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0 || bus_a.count[2] !== c) begin
      errs++; $display("FAIL idle_hold: got ticks=%0d count=%0d want 0/%0d", extra, bus_a.count[2], c);
    end
  endtask

  task automatic test_restart();
    int ticks;
    int n;
    bus_a.load_val[2] = 11'd0; bus_a.load[2] = 1'b1; bus_a.start[2] = 1'b1;
    step();
    bus_a.load[2] = 1'b0;
    ticks = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (bus_a.tick[2] === 1'b1) ticks++;
    end
    bus_a.start[2] = 1'b0;
    checks++;
    if (ticks !== 0) begin errs++; $display("FAIL restart_no_tick: got %0d ticks want 0", ticks); end
    n = 0;
    while (bus_a.tick[2] !== 1'b1 && n < 4) begin step(); n++; end
    checks++;
    if (bus_a.tick[2] !== 1'b1) begin errs++; $display("FAIL restart_resume: got timeout want tick"); end
    bus_a.stop[2] = 1'b1;
    step();
    bus_a.stop[2] = 1'b0;
  endtask

  task automatic test_width4();
    int n;
    logic [3:0] c0;
    bit loaded;
    bus_b.load_val[0] = 4'd15; bus_b.load[0] = 1'b1;
    step();
    bus_b.load[0] = 1'b0; bus_b.start[0] = 1'b1;
    step();
    bus_b.start[0] = 1'b0;
    n = 0;
    while (bus_b.tick[0] !== 1'b1 && n < 40) begin step(); n++; end
    checks++;
    if (bus_b.tick[0] !== 1'b1 || bus_b.count[0] !== 4'd15) begin
      errs++; $display("FAIL w4_first: got tick=%b count=%0d want 1/15", bus_b.tick[0], bus_b.count[0]);
    end
    n = 0;
    do begin step(); n++; end while (bus_b.tick[0] !== 1'b1 && n < 40);
    checks++;
    if (n !== 16) begin errs++; $display("FAIL w4_period_max: got %0d want 16", n); end
    n = 0;
    do begin
      loaded = 1'b0;
      if (n == 5) begin
        c0 = bus_b.count[0];
        bus_b.load_val[0] = 4'd2; bus_b.load[0] = 1'b1; loaded = 1'b1;
      end
      step(); n++;
      if (loaded) begin
        bus_b.load[0] = 1'b0;
        checks++;
        if (bus_b.count[0] !== c0 - 4'd1) begin
          errs++; $display("FAIL w4_load_midcount: got %0d want %0d", bus_b.count[0], c0 - 4'd1);
        end
      end
    end while (bus_b.tick[0] !== 1'b1 && n < 40);
    checks++;
    if (n !== 16) begin errs++; $display("FAIL w4_period_current: got %0d want 16", n); end
    n = 0;
    do begin step(); n++; end while (bus_b.tick[0] !== 1'b1 && n < 40);
    checks++;
    if (n !== 3) begin errs++; $display("FAIL w4_period_next: got %0d want 3", n); end
  endtask

  task automatic test_multi();
    int last [4];
    int bad  [4];
    int nt   [4];
    int expp [4];
    for (int ch = 0; ch < 4; ch++) begin
      last[ch] = -1; bad[ch] = 0; nt[ch] = 0; expp[ch] = (ch + 2) * 2;
      bus_a.load_val[ch] = 11'(ch + 1);
    end
    bus_a.oneshot = 4'b0000; bus_a.load = 4'hF; bus_a.start = 4'hF;
    step();
    bus_a.load = 4'h0; bus_a.start = 4'h0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      step();
      for (int ch = 0; ch < 4; ch++) begin
        if (bus_a.tick[ch] === 1'b1) begin
          if (last[ch] >= 0 && (cyc - last[ch]) != expp[ch]) bad[ch]++;
          last[ch] = cyc;
          nt[ch]++;
        end
      end
    end
    for (int ch = 0; ch < 4; ch++) begin
      checks++;
      if (bad[ch] !== 0) begin errs++; $display("FAIL multi_period ch%0d: got %0d bad intervals want 0 (period %0d)", ch, bad[ch], expp[ch]); end
      checks++;
      if (nt[ch] < (200 / expp[ch]) - 1) begin
        errs++; $display("FAIL multi_count ch%0d: got %0d ticks want >= %0d", ch, nt[ch], (200 / expp[ch]) - 1);
      end
    end
  endtask

  task automatic test_rst_mid();
    int ticks;
    bit busy_seen;
    step();
    rst_n = 1'b0;
    #2;
    checks++;
    if (bus_a.tick !== 4'b0000 || bus_a.busy !== 4'b0000) begin
      errs++; $display("FAIL rst_mid_ctrl: got tick=%b busy=%b want 0000/0000", bus_a.tick, bus_a.busy);
    end
    checks++;
    if (bus_a.count !== 44'd0 || bus_b.count !== 4'd0 || bus_b.busy !== 1'b0) begin
      errs++; $display("FAIL rst_mid_count: got a=%h b=%0d busy_b=%b want 0/0/0", bus_a.count, bus_b.count, bus_b.busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    ticks = 0; busy_seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (bus_a.tick !== 4'b0000 || bus_b.tick !== 1'b0) ticks++;
      if (bus_a.busy !== 4'b0000 || bus_b.busy !== 1'b0) busy_seen = 1'b1;
    end
    checks++;
    if (ticks !== 0 || busy_seen !== 1'b0) begin
      errs++; $display("FAIL rst_mid_after: got tick_cycles=%0d busy_seen=%b want 0/0", ticks, busy_seen);
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_oneshot_zero();
    test_load_start();
    test_restart();
    test_width4();
    test_multi();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
